// File: rtl/wb_interconnect_1ton.sv
// Single-master to NUM_SLAVES pipelined Wishbone interconnect: mask/base decode, lowest-index priority,
// one outstanding transaction, internal error slave. Define WB_IC_TIMEOUT_EN to enable the BUSY timeout.
module wb_interconnect_1ton #(
    parameter int unsigned NUM_SLAVES                  = 4,
    parameter int unsigned ADR_W                       = 32,
    parameter int unsigned DAT_W                       = 32,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK = '0,
    parameter int unsigned TIMEOUT_CYCLES              = 255
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        m_wb_cyc_i,
    input  logic                        m_wb_stb_i,
    input  logic                        m_wb_we_i,
    input  logic [ADR_W-1:0]            m_wb_adr_i,
    input  logic [DAT_W-1:0]            m_wb_dat_i,
    input  logic [DAT_W/8-1:0]          m_wb_sel_i,
    output logic                        m_wb_stall_o,
    output logic                        m_wb_ack_o,
    output logic                        m_wb_err_o,
    output logic [DAT_W-1:0]            m_wb_dat_o,
    output logic [NUM_SLAVES-1:0]       s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]       s_wb_stb_o,
    output logic                        s_wb_we_o,
    output logic [ADR_W-1:0]            s_wb_adr_o,
    output logic [DAT_W-1:0]            s_wb_dat_o,
    output logic [DAT_W/8-1:0]          s_wb_sel_o,
    input  logic [NUM_SLAVES-1:0]       s_wb_stall_i,
    input  logic [NUM_SLAVES-1:0]       s_wb_ack_i,
    input  logic [NUM_SLAVES-1:0]       s_wb_err_i,
    input  logic [NUM_SLAVES*DAT_W-1:0] s_wb_dat_i
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DERR = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sel_idx, sel_nxt;
    logic [NUM_SLAVES-1:0] hit;
    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic             tmo_hit;

    // Address decode; iterating downward leaves the lowest matching index
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            hit[i] = ((m_wb_adr_i & SLAVE_MASK[i*ADR_W +: ADR_W]) == SLAVE_BASE[i*ADR_W +: ADR_W]);
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

`ifdef WB_IC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;

    // Counter is held at zero outside BUSY, so it is clear on every BUSY entry
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            tmo_cnt <= '0;
        end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            sel_idx <= '0;
        end else begin
            state   <= state_nxt;
            sel_idx <= sel_nxt;
        end
    end

    // Next state and all bus outputs; everything is forced low while reset is asserted
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel_idx;
        m_wb_stall_o = 1'b0;
        m_wb_ack_o   = 1'b0;
        m_wb_err_o   = 1'b0;
        m_wb_dat_o   = '0;
        s_wb_cyc_o   = '0;
        s_wb_stb_o   = '0;
        s_wb_we_o    = 1'b0;
        s_wb_adr_o   = '0;
        s_wb_dat_o   = '0;
        s_wb_sel_o   = '0;
        if (reset_i) begin
            s_wb_we_o  = m_wb_we_i;
            s_wb_adr_o = m_wb_adr_i;
            s_wb_dat_o = m_wb_dat_i;
            s_wb_sel_o = m_wb_sel_i;
            case (state)
                IDLE: begin
                    if (hit_any) begin
                        s_wb_cyc_o[hit_idx] = m_wb_cyc_i;
                        s_wb_stb_o[hit_idx] = m_wb_cyc_i & m_wb_stb_i;
                        m_wb_stall_o        = s_wb_stall_i[hit_idx];
                        if (m_wb_cyc_i && m_wb_stb_i && !s_wb_stall_i[hit_idx]) begin
                            sel_nxt   = hit_idx;
                            state_nxt = BUSY;
                        end
                    end else if (m_wb_cyc_i && m_wb_stb_i) begin
                        state_nxt = DERR;
                    end
                end
                BUSY: begin
                    m_wb_stall_o        = 1'b1;
                    s_wb_cyc_o[sel_idx] = m_wb_cyc_i;
                    if (s_wb_err_i[sel_idx]) begin
                        m_wb_err_o = 1'b1;
                        state_nxt  = IDLE;
                    end else if (s_wb_ack_i[sel_idx]) begin
                        m_wb_ack_o = 1'b1;
                        m_wb_dat_o = s_wb_dat_i[sel_idx*DAT_W +: DAT_W];
                        state_nxt  = IDLE;
                    end else if (!m_wb_cyc_i) begin
                        state_nxt = IDLE;
                    end else if (tmo_hit) begin
                        s_wb_cyc_o = '0;
                        m_wb_err_o = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                DERR: begin
                    m_wb_stall_o = 1'b1;
                    m_wb_err_o   = 1'b1;
                    state_nxt    = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_interconnect_1ton.sv
// Directed bench for wb_interconnect_1ton: decode, stall, overlap priority, error slave, abort, reset, timeout.
module tb_wb_interconnect_1ton;

    localparam int unsigned NS = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [NS*AW-1:0] BASES = {32'h3000_0000, 32'h1000_8000, 32'h0000_0100, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASKS = {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_F00F};

    logic clk = 1'b0;
    logic reset_i;
    logic m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat_w;
    logic [DW/8-1:0] m_sel;
    logic m_stall, m_ack, m_err;
    logic [DW-1:0] m_dat_r;
    logic [NS-1:0] s_cyc, s_stb;
    logic s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w;
    logic [DW/8-1:0] s_sel;
    logic [NS-1:0] s_stall, s_ack, s_err;
    logic [NS*DW-1:0] s_dat_r;

    int n_asrt = 0;
    int n_fail = 0;

    wb_interconnect_1ton #(
        .NUM_SLAVES(NS), .ADR_W(AW), .DAT_W(DW),
        .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we), .m_wb_adr_i(m_adr),
        .m_wb_dat_i(m_dat_w), .m_wb_sel_i(m_sel),
        .m_wb_stall_o(m_stall), .m_wb_ack_o(m_ack), .m_wb_err_o(m_err), .m_wb_dat_o(m_dat_r),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_adr_o(s_adr),
        .s_wb_dat_o(s_dat_w), .s_wb_sel_o(s_sel),
        .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err), .s_wb_dat_i(s_dat_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i = 1'b0;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h1000_8004;
        m_dat_w = 32'h5555_AAAA; m_sel = 4'hF;
        s_stall = '0; s_ack = '0; s_err = '0; s_dat_r = '0;

        // outputs stay low while reset is held, even with an active master request
        #2;
        chk("rst_s_cyc", 64'(s_cyc), 64'h0);
        chk("rst_s_stb", 64'(s_stb), 64'h0);
        chk("rst_s_adr", 64'(s_adr), 64'h0);
        chk("rst_stall", 64'(m_stall), 64'h0);
        chk("rst_ack", 64'(m_ack), 64'h0);
        @(negedge clk); reset_i = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;

        // read hit on slave 2, zero-latency ack routed back
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h1000_8004; #1;
        chk("rd_s_stb", 64'(s_stb), 64'h4);
        chk("rd_s_cyc", 64'(s_cyc), 64'h4);
        chk("rd_stall", 64'(m_stall), 64'h0);
        @(negedge clk); m_stb = 1'b0; s_ack = 4'b0100;
        s_dat_r[2*DW +: DW] = 32'hDEAD_BEEF; s_dat_r[0 +: DW] = 32'h1111_1111; #1;
        chk("rd_ack", 64'(m_ack), 64'h1);
        chk("rd_dat", 64'(m_dat_r), 64'hDEAD_BEEF);
        chk("rd_busy_stall", 64'(m_stall), 64'h1);
        chk("rd_busy_stb", 64'(s_stb), 64'h0);
        @(negedge clk); s_ack = '0; m_cyc = 1'b0; #1;
        chk("rd_ack_done", 64'(m_ack), 64'h0);
        chk("rd_dat_zero", 64'(m_dat_r), 64'h0);

        // unmapped write goes to the error slave; err follows one cycle later even with cyc dropped
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h2000_0000;
        m_dat_w = 32'hA5A5_A5A5; #1;
        chk("um_s_stb", 64'(s_stb), 64'h0);
        chk("um_stall", 64'(m_stall), 64'h0);
        chk("um_s_we", 64'(s_we), 64'h1);
        chk("um_s_dat", 64'(s_dat_w), 64'hA5A5_A5A5);
        chk("um_err_early", 64'(m_err), 64'h0);
        @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; #1;
        chk("um_err", 64'(m_err), 64'h1);
        chk("um_ack", 64'(m_ack), 64'h0);
        chk("um_derr_stall", 64'(m_stall), 64'h1);
        @(negedge clk); #1;
        chk("um_err_once", 64'(m_err), 64'h0);

        // slave 1 stalls three cycles, then accepts
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0000_0104; s_stall = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("st_stall", 64'(m_stall), 64'h1);
            chk("st_s_stb", 64'(s_stb), 64'h2);
        end
        @(negedge clk); s_stall = '0; #1;
        chk("st_accept_stall", 64'(m_stall), 64'h0);
        chk("st_accept_stb", 64'(s_stb), 64'h2);
        @(negedge clk); m_stb = 1'b0; s_ack = 4'b0010; s_dat_r[1*DW +: DW] = 32'hCAFE_0001; #1;
        chk("st_ack", 64'(m_ack), 64'h1);
        chk("st_dat", 64'(m_dat_r), 64'hCAFE_0001);
        @(negedge clk); s_ack = '0; m_cyc = 1'b0;

        // overlapping decode: slave 0 wins, slave 1 ack ignored
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_0100; #1;
        chk("ov_s_stb", 64'(s_stb), 64'h1);
        chk("ov_s_cyc", 64'(s_cyc), 64'h1);
        @(negedge clk); m_stb = 1'b0; s_ack = 4'b0010; #1;
        chk("ov_ack_other", 64'(m_ack), 64'h0);
        chk("ov_dat_other", 64'(m_dat_r), 64'h0);
        @(negedge clk); s_ack = 4'b0001; s_dat_r[0 +: DW] = 32'h0BAD_F00D; #1;
        chk("ov_ack", 64'(m_ack), 64'h1);
        chk("ov_dat", 64'(m_dat_r), 64'h0BAD_F00D);
        @(negedge clk); s_ack = '0; m_cyc = 1'b0;

        // simultaneous ack and err: err wins
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3000_0010;
        @(negedge clk); m_stb = 1'b0; s_ack = 4'b1000; s_err = 4'b1000; #1;
        chk("pe_err", 64'(m_err), 64'h1);
        chk("pe_ack", 64'(m_ack), 64'h0);
        @(negedge clk); s_ack = '0; s_err = '0; m_cyc = 1'b0;

        // abort by dropping cyc; a late ack in IDLE is ignored
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3000_0010;
        @(negedge clk); m_cyc = 1'b0; m_stb = 1'b0; #1;
        chk("ab_ack", 64'(m_ack), 64'h0);
        chk("ab_err", 64'(m_err), 64'h0);
        chk("ab_s_cyc", 64'(s_cyc), 64'h0);
        @(negedge clk); s_ack = 4'b1000; #1;
        chk("ab_late_ack", 64'(m_ack), 64'h0);
        @(negedge clk); s_ack = '0;

        // reset while BUSY, then a clean transaction
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h1000_8004;
        @(negedge clk); m_stb = 1'b0; reset_i = 1'b0; s_ack = 4'b0100; #1;
        chk("rb_ack", 64'(m_ack), 64'h0);
        chk("rb_s_cyc", 64'(s_cyc), 64'h0);
        chk("rb_s_adr", 64'(s_adr), 64'h0);
        @(negedge clk); reset_i = 1'b1; #1;
        chk("rb_post_ack", 64'(m_ack), 64'h0);
        @(negedge clk); s_ack = '0; m_stb = 1'b1; #1;
        chk("rb_new_stb", 64'(s_stb), 64'h4);
        @(negedge clk); m_stb = 1'b0; s_ack = 4'b0100; s_dat_r[2*DW +: DW] = 32'h1234_5678; #1;
        chk("rb_new_ack", 64'(m_ack), 64'h1);
        chk("rb_new_dat", 64'(m_dat_r), 64'h1234_5678);
        @(negedge clk); s_ack = '0; m_cyc = 1'b0;

        // silent slave 3
        @(negedge clk); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3000_0010;
`ifdef WB_IC_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); m_stb = 1'b0; #1;
            if (k < 16) begin
                chk("to_wait_err", 64'(m_err), 64'h0);
            end else begin
                chk("to_err", 64'(m_err), 64'h1);
                chk("to_s_cyc", 64'(s_cyc), 64'h0);
            end
        end
        for (int k = 17; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) begin
                s_ack = 4'b1000; #1;
                chk("to_late_ack", 64'(m_ack), 64'h0);
            end
        end
`else
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); m_stb = 1'b0; #1;
            chk("nt_err", 64'(m_err), 64'h0);
        end
        chk("nt_stall", 64'(m_stall), 64'h1);
        @(negedge clk); s_ack = 4'b1000; s_dat_r[3*DW +: DW] = 32'h0000_0333; #1;
        chk("nt_ack", 64'(m_ack), 64'h1);
        chk("nt_dat", 64'(m_dat_r), 64'h0000_0333);
`endif
        @(negedge clk); s_ack = '0; m_cyc = 1'b0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
